adder_stim_checker: RTL and testbench
=====================================

// Module: adder_stim_checker
// PURPOSE
//   Self-checking driver end of the adder interface: owns the a/b side, observes sum/carry.
//   On start, walks every {a,b} combination of a WIDTH-bit adder in fixed order and
//   waits a settle time. It then compares {carry,sum} against a+b and reports error count and pass/fail.
//   Sits opposite a ha-style adder DUT (WIDTH=1) or any WIDTH-bit adder, in bench or BIST wrappers.
// PARAMETERS
//   WIDTH   1  operand width of a, b and sum
//   SETTLE  1  cycles held in WAIT between driving a vector and sampling it (legal range >=1)
// PORTS
//   clk        input   1          single clock, all state on rising edge
//   rst        input   1          asynchronous, active-high reset
//   start      input   1          begin a sweep; sampled only in IDLE or DONE
//   a_o        output  WIDTH      operand a to DUT (registered)
//   b_o        output  WIDTH      operand b to DUT (registered)
//   sum_i      input   WIDTH      DUT sum
//   carry_i    input   1          DUT carry
//   busy       output  1          high in DRIVE/WAIT/CHECK
//   done       output  1          high in DONE, held until next start or reset
//   pass       output  1          valid while done; 1 iff err_count==0
//   err_count  output  2*WIDTH+1  mismatching vectors in current sweep
//   fail_a     output  WIDTH      a of first failing vector (see CONFIGURATION)
//   fail_b     output  WIDTH      b of first failing vector (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (async, any state): state=IDLE; a_o=b_o=0; busy=done=pass=0;
//     err_count=0; vector index=0; wait counter=0; fail_a=fail_b=0.
//   - States IDLE, DRIVE, WAIT, CHECK, DONE. N = 2**(2*WIDTH) vectors.
//     Index i (2*WIDTH bits): a = i[2W-1:W], b = i[W-1:0].
//     WIDTH=1 order: (0,0),(0,1),(1,0),(1,1).
//   - IDLE/DONE + start=1 at edge E0: clear err_count, fail_a/fail_b, i=0, done=pass=0.
//     Load a_o/b_o with vector 0 and go to DRIVE; busy=1 from E0.
//   - DRIVE (1 cycle) -> WAIT. WAIT lasts SETTLE cycles (down-counter), then -> CHECK.
//   - CHECK (1 cycle): on its closing edge, compare {carry_i,sum_i} with the (WIDTH+1)-bit
//     a_o+b_o. On mismatch, err_count += 1.
//     If i < N-1: i+=1, load next vector on a_o/b_o, -> DRIVE.
//     If i == N-1: -> DONE; busy=0, done=1, pass = (final err_count==0),
//     including a mismatch on this last CHECK.
//   - Per-vector cost 2+SETTLE cycles. done rises at edge E0 + N*(2+SETTLE).
//     Example: WIDTH=1, SETTLE=1 gives E0+12.
//   - a_o/b_o are stable from DRIVE through CHECK of the same vector. In DONE they
//     keep the last vector, i.e. all-ones.
//   - start while busy: ignored, no restart, no effect on counts.
//   - start held high: in DONE it restarts every time it is sampled, so done pulses one cycle.
//   - err_count cannot overflow: max value N fits in 2*WIDTH+1 bits.
//   - X/Z on sum_i/carry_i in CHECK counts as a mismatch (use !== compare semantics in model).
// CONFIGURATION
//   FIRST_FAIL_CAPTURE_EN defined:
//     - On the first mismatch of a sweep (err_count==0 before the increment),
//       latch a_o->fail_a and b_o->fail_b.
//     - Later mismatches leave them unchanged.
//     - They are cleared on reset and on start.
//   Not defined:
//     - fail_a/fail_b are tied to 0 and the capture registers are not built.
//     - The ports remain present.
// TESTING
//   1. Reset mid-sweep: assert rst at cycle 5 after start -> next sample shows state IDLE,
//      busy=0, done=0, a_o=b_o=0, err_count=0.
//   2. WIDTH=1, SETTLE=1, correct half adder, pulse start -> busy 12 cycles.
//      a_o/b_o sequence 00,01,10,11; done=1 at E0+12; pass=1; err_count=0.
//   3. WIDTH=1, DUT with sum stuck at 0 -> err_count=2, pass=0.
//      With FIRST_FAIL_CAPTURE_EN: fail_a=0, fail_b=1.
//   4. WIDTH=1, carry stuck at 1 -> err_count=3, pass=0.
//      This includes a failure on the last vector (1,1) only if sum is also wrong;
//      check that the final CHECK is counted by forcing sum=1 on (1,1) -> err_count=4.
//   5. WIDTH=2, SETTLE=3, correct 2-bit adder -> 16 vectors.
//      done at E0+80; pass=1. start pulsed at cycle 10 is ignored.
//   6. start held high through DONE -> done high exactly 1 cycle.
//      The second sweep repeats the identical vector sequence and err_count restarts from 0.

Source files
------------

// File: rtl/adder_stim_checker.sv
// Exhaustive stimulus generator and checker for a WIDTH-bit adder: sweeps every {a,b},
// compares {carry,sum} against a+b and reports err_count/pass. Optional: FIRST_FAIL_CAPTURE_EN.
module adder_stim_checker #(
    parameter int WIDTH  = 1,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   a_o,
    output logic [WIDTH-1:0]   b_o,
    input  logic [WIDTH-1:0]   sum_i,
    input  logic               carry_i,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b
);
    localparam int IW = 2 * WIDTH;
    localparam int EW = 2 * WIDTH + 1;
    localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam logic [IW-1:0] LAST_IDX = {IW{1'b1}};
    localparam logic [IW-1:0] IDX_ONE  = IW'(1'b1);
    localparam logic [EW-1:0] ERR_ONE  = EW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRIVE = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_r, state_s;
    logic [IW-1:0]    idx_r, idx_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [EW-1:0]    err_r, err_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             pass_r, pass_s;
    logic [WIDTH:0]   expect_s;
    logic             mismatch_s;

    // Operands come straight from the vector index register, so a_o/b_o are registered.
    assign a_o       = idx_r[IW-1:WIDTH];
    assign b_o       = idx_r[WIDTH-1:0];
    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign err_count = err_r;

    // Reference sum; an unknown DUT response falls through to the mismatch branch.
    always_comb begin
        expect_s = {1'b0, a_o} + {1'b0, b_o};
        if ({carry_i, sum_i} == expect_s) begin
            mismatch_s = 1'b0;
        end else begin
            mismatch_s = 1'b1;
        end
    end

    // Next-state and next-output logic for the sweep FSM.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        cnt_s   = cnt_r;
        err_s   = err_r;
        busy_s  = busy_r;
        done_s  = done_r;
        pass_s  = pass_r;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_s = S_DRIVE;
                    idx_s   = {IW{1'b0}};
                    err_s   = {EW{1'b0}};
                    busy_s  = 1'b1;
                    done_s  = 1'b0;
                    pass_s  = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            S_DRIVE: begin
                state_s = S_WAIT;
                cnt_s   = CNT_LOAD;
            end
            S_WAIT: begin
                if (cnt_r <= CNT_ONE) begin
                    state_s = S_CHECK;
                    cnt_s   = {CW{1'b0}};
                end else begin
                    cnt_s   = cnt_r - CNT_ONE;
                end
            end
            S_CHECK: begin
                if (mismatch_s) begin
                    err_s = err_r + ERR_ONE;
                end else begin
                    err_s = err_r;
                end
                // The last vector's result is folded into pass in the same edge.
                if (idx_r == LAST_IDX) begin
                    state_s = S_DONE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    pass_s  = (err_s == {EW{1'b0}});
                end else begin
                    state_s = S_DRIVE;
                    idx_s   = idx_r + IDX_ONE;
                end
            end
            default: begin
                state_s = S_IDLE;
                idx_s   = {IW{1'b0}};
                cnt_s   = {CW{1'b0}};
                err_s   = {EW{1'b0}};
                busy_s  = 1'b0;
                done_s  = 1'b0;
                pass_s  = 1'b0;
            end
        endcase
    end

    // Sweep FSM state and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            idx_r   <= {IW{1'b0}};
            cnt_r   <= {CW{1'b0}};
            err_r   <= {EW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            cnt_r   <= cnt_s;
            err_r   <= err_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            pass_r  <= pass_s;
        end
    end

`ifdef FIRST_FAIL_CAPTURE_EN
    logic [WIDTH-1:0] fail_a_r, fail_a_s;
    logic [WIDTH-1:0] fail_b_r, fail_b_s;

    assign fail_a = fail_a_r;
    assign fail_b = fail_b_r;

    // First-failure capture: cleared on start, latched only while err_count is still zero.
    always_comb begin
        fail_a_s = fail_a_r;
        fail_b_s = fail_b_r;
        if ((state_r == S_IDLE || state_r == S_DONE) && start) begin
            fail_a_s = {WIDTH{1'b0}};
            fail_b_s = {WIDTH{1'b0}};
        end else if (state_r == S_CHECK && mismatch_s && err_r == {EW{1'b0}}) begin
            fail_a_s = a_o;
            fail_b_s = b_o;
        end else begin
            fail_a_s = fail_a_r;
            fail_b_s = fail_b_r;
        end
    end

    // First-failure capture registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_a_r <= {WIDTH{1'b0}};
            fail_b_r <= {WIDTH{1'b0}};
        end else begin
            fail_a_r <= fail_a_s;
            fail_b_r <= fail_b_s;
        end
    end
`else
    assign fail_a = {WIDTH{1'b0}};
    assign fail_b = {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_adder_stim_checker.sv
// Scoreboard bench: two checker instances (W=1/S=1 and W=2/S=3) facing a behavioural
// adder with selectable faults; expected sweep results are queued when start is issued.
module tb_adder_stim_checker;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] start_v;
    int         mode_v [2];

    logic       a1, b1, s1, c1, fa1, fb1;
    logic [2:0] err1;
    logic [1:0] a2, b2, s2, fa2, fb2;
    logic       c2;
    logic [4:0] err2;
    logic [1:0] busy_v, done_v, pass_v, dprev;
    logic [2:0] o1, o2;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int e0; int err; int pass; int fa; int fb;
    } exp_t;
    exp_t sb0[$];
    exp_t sb1[$];
    int   tr0[$];
    int   tr1[$];

    adder_stim_checker #(.WIDTH(1), .SETTLE(1)) u1 (
        .clk(clk), .rst(rst), .start(start_v[0]), .a_o(a1), .b_o(b1),
        .sum_i(s1), .carry_i(c1), .busy(busy_v[0]), .done(done_v[0]),
        .pass(pass_v[0]), .err_count(err1), .fail_a(fa1), .fail_b(fb1));

    adder_stim_checker #(.WIDTH(2), .SETTLE(3)) u2 (
        .clk(clk), .rst(rst), .start(start_v[1]), .a_o(a2), .b_o(b2),
        .sum_i(s2), .carry_i(c2), .busy(busy_v[1]), .done(done_v[1]),
        .pass(pass_v[1]), .err_count(err2), .fail_a(fa2), .fail_b(fb2));

    // Behavioural adder: 0 good, 1 sum stuck 0, 2 carry stuck 1, 3 carry stuck 1 and sum=1 on all-ones.
    function automatic logic [2:0] adder_out(int w, int a, int b, int mode);
        int r;
        int m;
        r = a + b;
        m = (1 << w) - 1;
        case (mode)
            1: r = r & ~m;
            2: r = r | (1 << w);
            3: begin
                r = r | (1 << w);
                if (a == m && b == m) r = (r & ~m) | 1;
            end
            default: r = a + b;
        endcase
        return 3'(r);
    endfunction

    always_comb o1 = adder_out(1, int'(a1), int'(b1), mode_v[0]);
    always_comb o2 = adder_out(2, int'(a2), int'(b2), mode_v[1]);
    assign {c1, s1} = o1[1:0];
    assign {c2, s2} = o2;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    function automatic int wid(int k);
        return (k == 0) ? 1 : 2;
    endfunction

    function automatic int per(int k);
        return (k == 0) ? 3 : 5;
    endfunction

    // Reference: count every {a,b} whose adder response differs from a+b.
    function automatic exp_t model(int k, int e0);
        exp_t e;
        int   w;
        bit   found;
        w = wid(k);
        e.e0 = e0; e.err = 0; e.fa = 0; e.fb = 0; found = 0;
        for (int a = 0; a < (1 << w); a++) begin
            for (int b = 0; b < (1 << w); b++) begin
                if (int'(adder_out(w, a, b, mode_v[k])) != a + b) begin
                    e.err++;
                    if (!found) begin e.fa = a; e.fb = b; found = 1; end
                end
            end
        end
`ifndef FIRST_FAIL_CAPTURE_EN
        e.fa = 0; e.fb = 0;
`endif
        e.pass = (e.err == 0) ? 1 : 0;
        return e;
    endfunction

    task automatic push(input int k, input exp_t e);
        if (k == 0) sb0.push_back(e); else sb1.push_back(e);
    endtask

    // Called at a negedge: the next posedge is E0.
    task automatic run_start(input int k);
        push(k, model(k, cyc + 1));
        start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int limit);
        int t = 0;
        while (!done_v[k] && t < limit) begin
            @(negedge clk);
            t++;
        end
        chk("done_timeout", int'(done_v[k]), 1);
    endtask

    // Monitor: records the operand trace while busy and scores each sweep at done's rising edge.
    always @(negedge clk) begin
        if (rst) begin
            sb0.delete(); sb1.delete(); tr0.delete(); tr1.delete();
            dprev = 2'b00;
        end else begin
            for (int k = 0; k < 2; k++) begin
                int   av, bv, ev, fav, fbv, n, p, bad, sz;
                exp_t e;
                av  = (k == 0) ? int'(a1) : int'(a2);
                bv  = (k == 0) ? int'(b1) : int'(b2);
                ev  = (k == 0) ? int'(err1) : int'(err2);
                fav = (k == 0) ? int'(fa1) : int'(fa2);
                fbv = (k == 0) ? int'(fb1) : int'(fb2);
                n   = 1 << (2 * wid(k));
                p   = per(k);
                if (busy_v[k]) begin
                    if (k == 0) tr0.push_back((av << 1) | bv);
                    else        tr1.push_back((av << 2) | bv);
                end
                if (done_v[k] && !dprev[k]) begin
                    sz = (k == 0) ? sb0.size() : sb1.size();
                    chk("unexpected_done", sz > 0 ? 1 : 0, 1);
                    if (sz > 0) begin
                        e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
                        chk("done_cycle", cyc, e.e0 + n * p);
                        chk("err_count", ev, e.err);
                        chk("pass", int'(pass_v[k]), e.pass);
                        chk("fail_a", fav, e.fa);
                        chk("fail_b", fbv, e.fb);
                        sz  = (k == 0) ? tr0.size() : tr1.size();
                        chk("busy_cycles", sz, n * p);
                        bad = 0;
                        for (int j = 0; j < sz; j++) begin
                            if (((k == 0) ? tr0[j] : tr1[j]) != j / p) bad++;
                        end
                        chk("vector_seq", bad, 0);
                    end
                    if (k == 0) tr0.delete(); else tr1.delete();
                end
            end
            dprev = done_v;
        end
    end

    initial begin
        exp_t e;
        rst = 1'b1; start_v = 2'b00; mode_v[0] = 0; mode_v[1] = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy_v), 0);
        chk("rst_done", int'(done_v), 0);
        chk("rst_pass", int'(pass_v), 0);
        chk("rst_ab", int'({a1, b1, a2, b2}), 0);
        chk("rst_err", int'(err1) + int'(err2), 0);
        chk("rst_fail", int'({fa1, fb1, fa2, fb2}), 0);
        rst = 1'b0;
        @(negedge clk);

        // Correct half adder, then done held and operands parked at all-ones.
        run_start(0);
        wait_done(0, 100);
        repeat (3) @(negedge clk);
        chk("done_held", int'(done_v[0]), 1);
        chk("done_ab", int'({a1, b1}), 3);

        // Fault sweeps on the 1-bit instance.
        for (int m = 1; m < 4; m++) begin
            mode_v[0] = m;
            run_start(0);
            wait_done(0, 100);
            @(negedge clk);
        end

        // Reset five cycles into a sweep.
        mode_v[0] = 0;
        run_start(0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", int'(busy_v[0]), 0);
        chk("mid_rst_done", int'(done_v[0]), 0);
        chk("mid_rst_ab", int'({a1, b1}), 0);
        chk("mid_rst_err", int'(err1), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 2-bit adder with an ignored start pulse mid-sweep.
        mode_v[1] = 0;
        run_start(1);
        repeat (8) @(negedge clk);
        start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        wait_done(1, 200);
        @(negedge clk);

        // Randomized fault modes, instances and idle gaps.
        for (int r = 0; r < 8; r++) begin
            int k;
            k = int'($urandom_range(0, 1));
            mode_v[k] = int'($urandom_range(0, 3));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_start(k);
            wait_done(k, 200);
            @(negedge clk);
        end

        // start held high through DONE: back-to-back sweeps, one-cycle done pulse.
        mode_v[0] = 1;
        e = model(0, cyc + 1);
        push(0, e);
        e.e0 = e.e0 + 4 * per(0) + 1;
        push(0, e);
        start_v[0] = 1'b1;
        @(negedge clk);
        wait_done(0, 100);
        @(negedge clk);
        chk("done_pulse", int'(done_v[0]), 0);
        chk("restart_busy", int'(busy_v[0]), 1);
        chk("restart_err", int'(err1), 0);
        wait_done(0, 100);
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("done_after_release", int'(done_v[0]), 1);
        chk("scoreboard_empty", sb0.size() + sb1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
